// File: rtl/latch_d.sv
// Clock-synchronous D latch emulation: transparent while E is high, holds the last capture otherwise.
// Optional LATCH_D_CAPTURE_FLAG_EN adds a registered VALID flag set by the first post-reset capture.
module latch_d #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             E,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
`ifdef LATCH_D_CAPTURE_FLAG_EN
   output logic             VALID,
`endif
   output logic [WIDTH-1:0] QN
);

   logic [WIDTH-1:0] hold_q;
   logic             transparent;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         hold_q <= RESET_VAL;
      end else if (E) begin
         hold_q <= D;
      end
   end

   // Reset suppresses transparency so Q shows the hold register while RST_N is low.
   assign transparent = RST_N & E;

   always_comb begin
      Q  = transparent ? D : hold_q;
      QN = ~Q;
   end

`ifdef LATCH_D_CAPTURE_FLAG_EN
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         VALID <= 1'b0;
      end else if (E) begin
         VALID <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_latch_d.sv
// Self-checking bench for latch_d: table vectors, hand-written corner sequences and random stimulus.
// Covers the VALID flag when LATCH_D_CAPTURE_FLAG_EN is defined.
module tb_latch_d;

   localparam int         W   = 8;
   localparam logic [7:0] RV2 = 8'hC3;

   logic         CLK;
   logic         RST_N;
   logic         E;
   logic [W-1:0] D;
   logic [W-1:0] Q, QN, Q2, QN2;
`ifdef LATCH_D_CAPTURE_FLAG_EN
   logic         VALID, VALID2;
`endif

   latch_d #(.WIDTH(W)) dut (
      .CLK(CLK), .RST_N(RST_N), .E(E), .D(D), .Q(Q),
`ifdef LATCH_D_CAPTURE_FLAG_EN
      .VALID(VALID),
`endif
      .QN(QN)
   );

   latch_d #(.WIDTH(W), .RESET_VAL(RV2)) dut_rv (
      .CLK(CLK), .RST_N(RST_N), .E(E), .D(D), .Q(Q2),
`ifdef LATCH_D_CAPTURE_FLAG_EN
      .VALID(VALID2),
`endif
      .QN(QN2)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Reference model: held value per instance and the capture flag.
   logic [7:0] m_h, m_h2;
   logic       m_v;
   int         n_pass = 0;
   int         n_total = 0;

   typedef struct {
      logic       rst_n;
      logic       e;
      logic [7:0] d;
      logic [7:0] exp_q;
      logic       exp_v;
   } vec_t;

   vec_t vecs[12];

   task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      else n_pass++;
   endtask

   task automatic cmp1(input string nm, input logic act, input logic exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      else n_pass++;
   endtask

   // Apply the rising edge to the model using the inputs present before it.
   task automatic clk_edge();
      @(posedge CLK);
      if (!RST_N) begin
         m_h  = 8'h00;
         m_h2 = RV2;
         m_v  = 1'b0;
      end else if (E) begin
         m_h  = D;
         m_h2 = D;
         m_v  = 1'b1;
      end
      #1;
   endtask

   task automatic drive(input logic r, input logic en, input logic [7:0] dv);
      RST_N = r;
      E     = en;
      D     = dv;
      #2;
   endtask

   // Compare both instances against the model, using current inputs.
   task automatic chk_model(input string nm);
      logic [7:0] eq, eq2;
      eq  = (RST_N && E) ? D : m_h;
      eq2 = (RST_N && E) ? D : m_h2;
      cmp({nm, "_q"},   Q,   eq);
      cmp({nm, "_qn"},  QN,  ~eq);
      cmp({nm, "_q2"},  Q2,  eq2);
      cmp({nm, "_qn2"}, QN2, ~eq2);
`ifdef LATCH_D_CAPTURE_FLAG_EN
      cmp1({nm, "_valid"},  VALID,  m_v);
      cmp1({nm, "_valid2"}, VALID2, m_v);
`endif
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 8'hA5, 8'hA5, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 8'h00, 8'hA5, 1'b1};
      vecs[6]  = '{1'b1, 1'b0, 8'h3C, 8'hA5, 1'b1};
      vecs[7]  = '{1'b1, 1'b0, 8'hFF, 8'hA5, 1'b1};
      vecs[8]  = '{1'b1, 1'b1, 8'h5A, 8'h5A, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 8'hFF, 8'h5A, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 8'h77, 8'h00, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 8'h01, 8'h01, 1'b0};

      m_h = 'x; m_h2 = 'x; m_v = 1'b0;
      RST_N = 1'b0; E = 1'b1; D = 8'hFF;
      clk_edge();
      #2;
      cmp("reset_q", Q, 8'h00);
      cmp("reset_qn", QN, 8'hFF);
      cmp("reset_q_rv", Q2, RV2);
      cmp("reset_qn_rv", QN2, ~RV2);
`ifdef LATCH_D_CAPTURE_FLAG_EN
      cmp1("reset_valid", VALID, 1'b0);
`endif
      clk_edge();

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].rst_n, vecs[i].e, vecs[i].d);
         cmp($sformatf("vec%0d_q", i), Q, vecs[i].exp_q);
         cmp($sformatf("vec%0d_qn", i), QN, ~vecs[i].exp_q);
`ifdef LATCH_D_CAPTURE_FLAG_EN
         cmp1($sformatf("vec%0d_valid", i), VALID, vecs[i].exp_v);
`endif
         chk_model($sformatf("vec%0d_model", i));
         clk_edge();
      end

      // Transparency within one cycle: D change shows on Q before the next edge.
      drive(1'b1, 1'b1, 8'h00);
      cmp("transp_lo_q", Q, 8'h00);
      drive(1'b1, 1'b1, 8'hFF);
      cmp("transp_hi_q", Q, 8'hFF);
      cmp("transp_hi_qn", QN, 8'h00);
      clk_edge();

      // Simultaneous E fall and D change: the pre-edge D is held for several cycles.
      drive(1'b1, 1'b1, 8'hA5);
      clk_edge();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b0, 8'(k * 17));
         cmp($sformatf("hold%0d_q", k), Q, 8'hA5);
         cmp($sformatf("hold%0d_qn", k), QN, 8'h5A);
         clk_edge();
      end

      // Reset mid-operation with E high: previous H visible until the edge.
      drive(1'b1, 1'b1, 8'h81);
      clk_edge();
      drive(1'b0, 1'b1, 8'hFF);
      cmp("midrst_pre_q", Q, 8'h81);
      clk_edge();
      drive(1'b0, 1'b1, 8'hFF);
      cmp("midrst_post_q", Q, 8'h00);
      cmp("midrst_post_q_rv", Q2, RV2);
      clk_edge();
      drive(1'b1, 1'b0, 8'hEE);
      cmp("midrst_rel_q", Q, 8'h00);
      cmp("midrst_rel_qn", QN, 8'hFF);
      clk_edge();

      for (int n = 0; n < 300; n++) begin
         drive(($urandom_range(0, 7) != 0), 1'($urandom), 8'($urandom));
         chk_model($sformatf("rnd%0d", n));
         clk_edge();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
